axi4_slave_bresp_scheduler: RTL
===============================

// Module: axi4_slave_bresp_scheduler
// PURPOSE
//  Sequences the AXI4 slave write-response (B) channel for multiple outstanding writes.
//  Queues each accepted AW transaction (ID and decode status) and marks it complete on its W-burst wlast.
//  Issues one B response per completed burst, in AW order, with a full valid/ready handshake.
//  Sits between the AW/W channel logic and the B channel; aw_full throttles awready upstream.
// PARAMETERS
//  ID_WIDTH  4  width of awid/bid
//  DEPTH     4  max outstanding writes (AW accepted, B not yet handshaken); power of 2, >=2
// PORTS
//  clk         in   1         clock, all logic on posedge
//  rst         in   1         asynchronous, active-low reset
//  aw_push     in   1         AW handshake this cycle (awvalid&awready)
//  aw_id       in   ID_WIDTH  awid of the pushed transaction
//  aw_decerr   in   1         pushed address failed decode -> DECERR
//  w_done      in   1         last W beat handshake this cycle (wvalid&wready&wlast)
//  w_slverr    in   1         qualifies w_done: burst hit a slave error -> SLVERR
//  bready      in   1         master accepts B response
//  bvalid      out  1         B response valid
//  bid         out  ID_WIDTH  response ID (= awid of head entry)
//  bresp       out  2         OKAY 00 / SLVERR 10 / DECERR 11 (EXOKAY never issued)
//  aw_full     out  1         DEPTH entries outstanding; upstream must deassert awready
//  outstanding out  $clog2(DEPTH)+1  entries queued (AW pushed, B not yet done)
//  err_sticky  out  2         [0] aw_push while full, [1] w_done with no open AW; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, async): all pointers 0, bvalid=0, bid=0, bresp=00, err_sticky=0, state IDLE.
//    Mid-burst reset drops all queued entries; no B is issued for them.
//  - Three pointers of $clog2(DEPTH)+1 bits, MSB for wrap:
//    wr_ptr (AW push), dn_ptr (next entry awaiting wlast), rd_ptr (next B to issue).
//    outstanding = wr_ptr-rd_ptr; completed = dn_ptr-rd_ptr; open = wr_ptr-dn_ptr.
//  - aw_push and !aw_full: store {aw_id, aw_decerr}, wr_ptr++. aw_push when full: ignored, err_sticky[0]=1.
//  - w_done: if open>0 or aw_push same cycle (counts that entry): entry[dn_ptr].slverr=w_slverr, dn_ptr++.
//    Otherwise ignored, err_sticky[1]=1. AW must precede or coincide with its wlast.
//  - bresp priority: decerr -> 11, else slverr -> 10, else 00.
//  - FSM B_IDLE/B_VALID, registered outputs:
//    B_IDLE: completed>0 -> load bid/bresp from entry[rd_ptr], bvalid=1, go B_VALID.
//    B_VALID: bvalid, bid, bresp held stable while !bready (AXI rule).
//      On bready: rd_ptr++. If another entry is complete (counting one finishing this cycle),
//      load it and keep bvalid=1 (back-to-back, no bubble); else bvalid=0, go B_IDLE.
//  - Latency: w_done at edge N -> bvalid=1 after edge N+1; min B throughput 1/cycle.
//  - Simultaneous push, w_done and B handshake in one cycle: all three take effect.
//    aw_full evaluates from the pre-update outstanding (a slot freed by bready is visible next cycle).
//  - bvalid never depends combinationally on bready; no B without a matching prior AW push.
// STRUCTURE
//  - axi4_slave_pkg: resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11};
//    bsched_state_t {B_IDLE, B_VALID}; shared with the read-response path.
//  - Sub-module axi4_slave_resp_queue: DEPTH-entry register array of {id, decerr, slverr}
//    with a write port (wr_ptr) and an update port (dn_ptr); the top holds pointers and FSM.
// TESTING
//  - Reset with rst low mid-B_VALID (bvalid=1) -> bvalid/bid/bresp=0 immediately; no later B.
//  - Single write: push id=3, w_done two cycles later, bready=1 -> one B, bid=3, bresp=00, then bvalid=0.
//  - Backpressure: push ids 1,2,5 (5 with aw_decerr), complete all, bready=0 for 4 cycles ->
//    bid=1 held stable; then bready=1 -> B ids 1,2,5 on consecutive cycles, bresp 00,00,11.
//  - Full: DEPTH=4, push 4 ids -> aw_full=1, outstanding=4;
//    5th push -> err_sticky[0]=1 and the id is not queued. One B handshake -> aw_full=0 next cycle.
//  - Errors: w_done with no open AW -> err_sticky[1]=1, no B.
//    Push+w_done same cycle with w_slverr=1, id=7 -> bid=7, bresp=10.
//  - Random: push/w_done/bready at 50% each for 10k cycles vs. scoreboard FIFO ->
//    in-order bid/bresp, outstanding<=DEPTH, and no bid/bresp change while bvalid&!bready.

Source files
------------

// File: rtl/axi4_slave_pkg.sv
// Shared AXI4 slave types: response encoding and the response-scheduler FSM states.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [0:0] {
    B_IDLE  = 1'b0,
    B_VALID = 1'b1
  } bsched_state_t;

  // A decode error outranks a slave error; EXOKAY is never produced here.
  function automatic resp_t resp_encode(input logic decerr, input logic slverr);
    resp_t r;
    if (decerr) begin
      r = DECERR;
    end else if (slverr) begin
      r = SLVERR;
    end else begin
      r = OKAY;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_slave_resp_queue.sv
// Storage for outstanding write responses: {id, decerr, slverr} per entry.
// Write port fills a fresh entry on AW, update port records slverr on wlast.
// The read port looks at the post-update contents so the scheduler can load
// an entry that is being written or completed in the same cycle.
module axi4_slave_resp_queue
  import axi4_slave_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [ID_WIDTH-1:0]        wr_id,
  input  logic                       wr_decerr,
  input  logic                       up_en,
  input  logic [$clog2(DEPTH)-1:0]   up_idx,
  input  logic                       up_slverr,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ID_WIDTH-1:0]        rd_id,
  output resp_t                      rd_resp
);

  logic [ID_WIDTH-1:0] id_q     [DEPTH];
  logic [ID_WIDTH-1:0] id_d     [DEPTH];
  logic                decerr_q [DEPTH];
  logic                decerr_d [DEPTH];
  logic                slverr_q [DEPTH];
  logic                slverr_d [DEPTH];

  // Next array contents; the update port is applied last so a same-cycle
  // push and completion of one slot keeps the new slverr.
  always_comb begin
    id_d     = id_q;
    decerr_d = decerr_q;
    slverr_d = slverr_q;
    if (wr_en) begin
      id_d[wr_idx]     = wr_id;
      decerr_d[wr_idx] = wr_decerr;
      slverr_d[wr_idx] = 1'b0;
    end else begin
      id_d[wr_idx]     = id_q[wr_idx];
    end
    if (up_en) begin
      slverr_d[up_idx] = up_slverr;
    end else begin
      slverr_d[up_idx] = slverr_d[up_idx];
    end
  end

  // Entry storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]     <= '0;
        decerr_q[i] <= 1'b0;
        slverr_q[i] <= 1'b0;
      end
    end else begin
      id_q     <= id_d;
      decerr_q <= decerr_d;
      slverr_q <= slverr_d;
    end
  end

  assign rd_id   = id_d[rd_idx];
  assign rd_resp = resp_encode(decerr_d[rd_idx], slverr_d[rd_idx]);

endmodule

// File: rtl/axi4_slave_bresp_scheduler.sv
// AXI4 slave B-channel scheduler: tracks outstanding writes in AW order,
// marks them complete on wlast, and issues one B response per burst.
module axi4_slave_bresp_scheduler
  import axi4_slave_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aw_push,
  input  logic [ID_WIDTH-1:0]      aw_id,
  input  logic                     aw_decerr,
  input  logic                     w_done,
  input  logic                     w_slverr,
  input  logic                     bready,
  output logic                     bvalid,
  output logic [ID_WIDTH-1:0]      bid,
  output logic [1:0]               bresp,
  output logic                     aw_full,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [1:0]               err_sticky
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] dn_ptr_q, dn_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       err_q, err_d;

  bsched_state_t       state_q, state_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  resp_t               bresp_q, bresp_d;

  logic [PTR_W-1:0]    outstanding_s;
  logic [PTR_W-1:0]    completed_s;
  logic [PTR_W-1:0]    completed_next_s;
  logic [PTR_W-1:0]    open_s;
  logic                full_s;
  logic                push_ok_s;
  logic                w_ok_s;
  logic                b_hs_s;
  logic [ID_WIDTH-1:0] q_rd_id_s;
  resp_t               q_rd_resp_s;

  assign outstanding_s    = wr_ptr_q - rd_ptr_q;
  assign completed_s      = dn_ptr_q - rd_ptr_q;
  assign open_s           = wr_ptr_q - dn_ptr_q;
  assign full_s           = (outstanding_s == PTR_DEPTH);
  assign push_ok_s        = aw_push & ~full_s;
  assign w_ok_s           = w_done & ((open_s != '0) | push_ok_s);
  assign b_hs_s           = bvalid_q & bready;
  assign completed_next_s = dn_ptr_d - rd_ptr_d;

  // Pointer advance and sticky protocol-error capture.
  always_comb begin
    err_d = err_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (w_ok_s) begin
      dn_ptr_d = dn_ptr_q + PTR_ONE;
    end else begin
      dn_ptr_d = dn_ptr_q;
    end
    if (b_hs_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (aw_push && full_s) begin
      err_d[0] = 1'b1;
    end else begin
      err_d[0] = err_q[0];
    end
    if (w_done && !w_ok_s) begin
      err_d[1] = 1'b1;
    end else begin
      err_d[1] = err_q[1];
    end
  end

  // B-channel FSM: loads the head entry and holds it until bready; chains
  // straight into the next completed entry to avoid a bubble.
  always_comb begin
    state_d  = state_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    case (state_q)
      B_IDLE: begin
        if (completed_s != '0) begin
          state_d  = B_VALID;
          bvalid_d = 1'b1;
          bid_d    = q_rd_id_s;
          bresp_d  = q_rd_resp_s;
        end else begin
          state_d  = B_IDLE;
          bvalid_d = 1'b0;
        end
      end
      B_VALID: begin
        if (bready) begin
          if (completed_next_s != '0) begin
            state_d  = B_VALID;
            bvalid_d = 1'b1;
            bid_d    = q_rd_id_s;
            bresp_d  = q_rd_resp_s;
          end else begin
            state_d  = B_IDLE;
            bvalid_d = 1'b0;
          end
        end else begin
          state_d  = B_VALID;
          bvalid_d = 1'b1;
        end
      end
      default: begin
        state_d  = B_IDLE;
        bvalid_d = 1'b0;
      end
    endcase
  end

  // Pointer, error and B-output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      dn_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 2'b00;
      state_q  <= B_IDLE;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= OKAY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      dn_ptr_q <= dn_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      state_q  <= state_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

  axi4_slave_resp_queue #(
    .ID_WIDTH (ID_WIDTH),
    .DEPTH    (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push_ok_s),
    .wr_idx    (wr_ptr_q[IDX_W-1:0]),
    .wr_id     (aw_id),
    .wr_decerr (aw_decerr),
    .up_en     (w_ok_s),
    .up_idx    (dn_ptr_q[IDX_W-1:0]),
    .up_slverr (w_slverr),
    .rd_idx    (rd_ptr_d[IDX_W-1:0]),
    .rd_id     (q_rd_id_s),
    .rd_resp   (q_rd_resp_s)
  );

  assign bvalid      = bvalid_q;
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign aw_full     = full_s;
  assign outstanding = outstanding_s;
  assign err_sticky  = err_q;

endmodule
